// File: rtl/cl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cl_pkg
// Description : Shared definitions for the bit-serial logic sequencer:
//               logic-cell op codes and sequencer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cl_pkg;

  // Logic-cell operation codes
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  // Sequencer FSM state encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cl_bit.sv
`default_nettype none
// ============================================================================
// Module      : cl_bit
// Description : 1-bit combinational logic cell. Selects AND / OR / XOR of
//               a and b, or the inverse of a (b ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module cl_bit
  import cl_pkg::*;
(
  output logic       out,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] s
);

  // Select the logic function from the op code
  always_comb begin
    out = 1'b0;
    case (s)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_NOTA: out = ~a;
      default: out = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cl_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : cl_serial_seq
// Description : Bit-serial sequencer around the 1-bit logic cell. Streams two
//               W-bit operands LSB-first through the cell, one bit per clock,
//               and assembles the result word in a right-shifting register.
// Revision    : 1.0 - initial release
// ============================================================================
module cl_serial_seq
  import cl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int              CNT_W  = $clog2(W);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [1:0]       r_op_q;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_result;
  logic             w_bit;
  logic             w_capture;

  // Operands are accepted only from IDLE or DONE; a start during SHIFT is ignored
  assign w_capture = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  cl_bit u_cell (
    .out (w_bit),
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .s   (r_op_q)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: W shift cycles, one done cycle, optional back-to-back start
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == c_LAST) w_next = S_DONE;
      S_DONE:  w_next = start ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, bit streaming and result assembly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_op_q   <= 2'b00;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_capture) begin
      r_a_sh <= a_in;
      r_b_sh <= b_in;
      r_op_q <= op;
      r_cnt  <= '0;
    end else if (r_state == S_SHIFT) begin
      r_result <= {w_bit, r_result[W-1:1]};
      r_a_sh   <= {1'b0, r_a_sh[W-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[W-1:1]};
      // Hold at the last index so the counter never wraps
      if (r_cnt != c_LAST) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Status flags decode directly from the state register
  assign busy   = (r_state == S_SHIFT);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_cl_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cl_serial_seq
// Description : Self-checking bench for cl_serial_seq with W=4: directed
//               vector table, multi-cycle corner sequences and random runs
//               compared against a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cl_serial_seq;

  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  cl_serial_seq #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Word-level reference: the serial result equals the bitwise op on whole words
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] o);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; returns in the first cycle after it
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
    a_in  = a;
    b_in  = b;
    op    = o;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc=0 means it never came
  task automatic wait_done(output int cyc, output int busy_n);
    cyc    = 0;
    busy_n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        cyc = i;
        break;
      end
      if (busy) busy_n++;
      tick();
    end
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] o, input logic [W-1:0] exp);
    int cyc, bn;
    start_op(a, b, o);
    wait_done(cyc, bn);
    check({name, "_latency"}, cyc, W + 1);
    check({name, "_busy_cycles"}, bn, W);
    check({name, "_result"}, result, exp);
    tick();
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    int   cyc, bn, dcount;
    logic [W-1:0] ra, rb, held;
    logic [1:0]   rop;

    vecs[0] = '{a: 4'b1100, b: 4'b1010, op: 2'b00, exp: 4'b1000};
    vecs[1] = '{a: 4'b1100, b: 4'b1010, op: 2'b01, exp: 4'b1110};
    vecs[2] = '{a: 4'b1100, b: 4'b1010, op: 2'b10, exp: 4'b0110};
    vecs[3] = '{a: 4'b1100, b: 4'b1010, op: 2'b11, exp: 4'b0011};
    vecs[4] = '{a: 4'b0000, b: 4'b1111, op: 2'b11, exp: 4'b1111};
    vecs[5] = '{a: 4'b1001, b: 4'b0110, op: 2'b01, exp: 4'b1111};

    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    a_in    = '0;
    b_in    = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 4'b0000);
    #5 reset_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    end

    // Start while busy is ignored
    start_op(4'b1111, 4'b0000, 2'b01);
    tick();
    a_in  = 4'b0000;
    op    = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    held   = 'x;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        dcount++;
        held = result;
      end
      tick();
    end
    check("busy_start_result", held, 4'b1111);
    check("busy_start_done_count", dcount, 1);

    // Back-to-back start in the DONE cycle
    start_op(4'b0101, 4'b0011, 2'b10);
    wait_done(cyc, bn);
    check("b2b_first_result", result, 4'b0110);
    a_in  = 4'b1111;
    b_in  = 4'b1001;
    op    = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_done(cyc, bn);
    check("b2b_latency", cyc, W + 1);
    check("b2b_second_result", result, 4'b1001);
    tick();

    // Asynchronous reset during the 2nd SHIFT cycle
    start_op(4'b1111, 4'b1111, 2'b01);
    tick();
    #5 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", result, 4'b0000);
    tick();
    #3 reset_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcount++;
      tick();
    end
    check("midrst_no_done", dcount, 0);
    run_check("after_rst", 4'b1010, 4'b0101, 2'b01, 4'b1111);

    // Result holds while idle
    held = result;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold_result%0d", i), result, held);
      check($sformatf("hold_done%0d", i), done, 1'b0);
    end

    // Randomized runs against the word-level model, some back-to-back
    for (int i = 0; i < 30; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 2'($urandom_range(0, 3));
      start_op(ra, rb, rop);
      wait_done(cyc, bn);
      check($sformatf("rnd%0d_latency", i), cyc, W + 1);
      check($sformatf("rnd%0d_result", i), result, model(ra, rb, rop));
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
